instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter: RESET_PC, 8'h00, PC value loaded on reset.
REQ-002 SHALL have parameter: TIMEOUT, 15, maximum FETCH cycles waiting for imem_ack (used only under REQ-030).
REQ-003 SHALL have port: clk  in  1  rising-edge system clock.
REQ-004 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: run  in  1  fetch enable.
REQ-006 SHALL have ports: imem_req out 1, imem_addr out 8, imem_rdata in 8, imem_ack in 1  instruction-memory handshake.
REQ-007 SHALL have ports: inst1 out 3 (IR[7:5] opcode), inst2 out 1 (IR[4] funct), imm out 4 (IR[3:0]), inst_valid out 1  feed to ctrl.
REQ-008 SHALL have ports: jctrl, jrctrl, beqctrl, jalctrl  in  1 each  ctrl decode results; zero in 1 ALU zero flag; ra_in in 8 return-address register value.
REQ-009 SHALL have ports: pc out 8, link_pc out 8, link_we out 1, fetch_err out 1.

Function
REQ-010 SHALL implement FSM states IDLE, FETCH, ISSUE, HALT; all outputs registered.
REQ-011 IDLE: imem_req=0, inst_valid=0; SHALL move to FETCH on the first clock edge with run=1.
REQ-012 FETCH: imem_req=1, imem_addr=pc, held stable until the edge that samples imem_ack=1; request SHALL NOT be withdrawn before ack, regardless of run.
REQ-013 On that ack edge, IR SHALL capture imem_rdata and FSM SHALL move to ISSUE.
REQ-014 ISSUE SHALL last exactly one cycle with inst_valid=1; ctrl inputs are sampled at the end-of-ISSUE edge.
REQ-015 End-of-ISSUE next PC SHALL follow priority: jrctrl -> ra_in; else jctrl|jalctrl -> {imm,4'b0000}; else beqctrl&zero -> pc+1+sign_extend(imm); else pc+1.
REQ-016 All PC arithmetic SHALL be modulo 256 (8'hFF+1=8'h00; backward branch below 8'h00 wraps).
REQ-017 If jalctrl at end of ISSUE: link_pc SHALL load pc+1 and link_we SHALL pulse high for exactly the following cycle.
REQ-018 After ISSUE, FSM SHALL go to FETCH if run=1, else IDLE.
REQ-019 Minimum throughput: one instruction per 2 cycles (ack in the first FETCH cycle).
REQ-020 inst1/inst2/imm SHALL hold IR contents outside ISSUE; consumers SHALL qualify them with inst_valid.
REQ-021 ctrl inputs SHALL be ignored in every state except ISSUE.
REQ-022 imem_ack outside FETCH SHALL be ignored.

Reset
REQ-023 On rst_n low, outputs SHALL immediately become: pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, IR=8'h00, inst_valid=0, link_pc=8'h00, link_we=0, fetch_err=0; state=IDLE.
REQ-024 Reset asserted mid-FETCH SHALL drop imem_req in the same cycle, with no IR capture.
REQ-025 After rst_n deasserts, first fetch SHALL address RESET_PC.

Configuration
REQ-030 Macro FETCH_TIMEOUT_EN, when defined, SHALL enable a 4-bit wait counter cleared on entering FETCH; if TIMEOUT cycles elapse without ack, FSM SHALL enter HALT with fetch_err=1 and imem_req=0.
REQ-031 HALT SHALL be exited only by reset.
REQ-032 Without FETCH_TIMEOUT_EN, FETCH SHALL wait indefinitely; HALT SHALL be unreachable; fetch_err SHALL be tied 0.

Verification
REQ-040 Reset, run=1, ack on first FETCH cycle with rdata=8'h61 and no ctrl flags -> inst1=3'b011, inst2=0, imm=4'h1, inst_valid one cycle; pc 00->01; next imem_addr=01.
REQ-041 pc=8'h10, IR imm=4'hE, beqctrl=1, zero=1 -> pc=8'h0F; with zero=0 -> pc=8'h11.
REQ-042 pc=8'h20, jalctrl=1, imm=4'h5 -> pc=8'h50, link_pc=8'h21, link_we high exactly one cycle; same cycle jrctrl=1, ra_in=8'hA7 -> pc=8'hA7, link_we still pulses.
REQ-043 pc=8'hFF, no redirect -> pc=8'h00; ack delayed 3 cycles -> imem_addr stable throughout, run dropped mid-wait -> fetch completes, ISSUE, then IDLE.
REQ-044 rst_n low during FETCH -> imem_req=0 same cycle, pc=RESET_PC; with FETCH_TIMEOUT_EN and no ack for 15 cycles -> fetch_err=1, imem_req=0, stays in HALT until reset.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch FSM: request/ack memory handshake, IR capture, one-cycle issue and next-PC select.
// Optional FETCH_TIMEOUT_EN adds an ack watchdog that parks the unit in HALT with fetch_err set.
module instr_fetch #(
  parameter logic [7:0]  RESET_PC = 8'h00,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic [7:0] imem_rdata,
  input  logic       imem_ack,
  output logic [2:0] inst1,
  output logic       inst2,
  output logic [3:0] imm,
  output logic       inst_valid,
  input  logic       jctrl,
  input  logic       jrctrl,
  input  logic       beqctrl,
  input  logic       jalctrl,
  input  logic       zero,
  input  logic [7:0] ra_in,
  output logic [7:0] pc,
  output logic [7:0] link_pc,
  output logic       link_we,
  output logic       fetch_err
);

  typedef enum logic [1:0] {StIdle, StFetch, StIssue, StHalt} state_e;

  if ((TIMEOUT == 0) || (TIMEOUT > 16)) begin : g_timeout_range
    $error("instr_fetch: TIMEOUT must fit the 4-bit wait counter (1..16)");
  end

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] link_pc_q, link_pc_d;
  logic       link_we_q, link_we_d;
  logic       imem_req_q, imem_req_d;
  logic       inst_valid_q, inst_valid_d;
  logic [7:0] pc_inc, br_tgt;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [3:0] WaitLast = 4'(TIMEOUT - 1);
  logic [3:0] wait_q, wait_d;
  logic       fetch_err_q, fetch_err_d;
`endif

  assign pc_inc = pc_q + 8'd1;
  assign br_tgt = pc_inc + {{4{ir_q[3]}}, ir_q[3:0]};

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    link_pc_d = link_pc_q;
    link_we_d = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    wait_d      = wait_q;
    fetch_err_d = fetch_err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (run) begin
          state_d = StFetch;
`ifdef FETCH_TIMEOUT_EN
          wait_d  = 4'd0;
`endif
        end
      end
      StFetch: begin
        // Request is held until ack regardless of run.
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = StIssue;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (wait_q == WaitLast) begin
          state_d     = StHalt;
          fetch_err_d = 1'b1;
        end else begin
          wait_d = wait_q + 4'd1;
        end
`endif
      end
      StIssue: begin
        if (jrctrl) begin
          pc_d = ra_in;
        end else if (jctrl || jalctrl) begin
          pc_d = {ir_q[3:0], 4'b0000};
        end else if (beqctrl && zero) begin
          pc_d = br_tgt;
        end else begin
          pc_d = pc_inc;
        end
        if (jalctrl) begin
          link_pc_d = pc_inc;
          link_we_d = 1'b1;
        end
        state_d = run ? StFetch : StIdle;
`ifdef FETCH_TIMEOUT_EN
        wait_d  = 4'd0;
`endif
      end
      StHalt: begin
        state_d = StHalt;
      end
    endcase
    imem_req_d   = (state_d == StFetch);
    inst_valid_d = (state_d == StIssue);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      ir_q         <= 8'h00;
      link_pc_q    <= 8'h00;
      link_we_q    <= 1'b0;
      imem_req_q   <= 1'b0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      link_pc_q    <= link_pc_d;
      link_we_q    <= link_we_d;
      imem_req_q   <= imem_req_d;
      inst_valid_q <= inst_valid_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q      <= 4'd0;
      fetch_err_q <= 1'b0;
    end else begin
      wait_q      <= wait_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign fetch_err = fetch_err_q;
`else
  assign fetch_err = 1'b0;
`endif

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign inst1      = ir_q[7:5];
  assign inst2      = ir_q[4];
  assign imm        = ir_q[3:0];
  assign inst_valid = inst_valid_q;
  assign pc         = pc_q;
  assign link_pc    = link_pc_q;
  assign link_we    = link_we_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: driver pushes expectations, negedge monitor pops and compares.
module tb_instr_fetch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata;
  logic       imem_ack;
  logic [2:0] inst1;
  logic       inst2;
  logic [3:0] imm;
  logic       inst_valid;
  logic       jctrl, jrctrl, beqctrl, jalctrl, zero;
  logic [7:0] ra_in;
  logic [7:0] pc, link_pc;
  logic       link_we, fetch_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  instr_fetch #(.RESET_PC(8'h00), .TIMEOUT(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .inst1      (inst1),
    .inst2      (inst2),
    .imm        (imm),
    .inst_valid (inst_valid),
    .jctrl      (jctrl),
    .jrctrl     (jrctrl),
    .beqctrl    (beqctrl),
    .jalctrl    (jalctrl),
    .zero       (zero),
    .ra_in      (ra_in),
    .pc         (pc),
    .link_pc    (link_pc),
    .link_we    (link_we),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] rdata;
    int         delay;
    bit         drop;
    bit         j, jr, beq, jal, zr;
    logic [7:0] ra;
    logic [7:0] next;
    logic [7:0] link;
    bit         run_next;
  } vec_t;

  logic [7:0]  addr_q[$];
  logic [15:0] inst_q[$];
  logic [7:0]  next_q[$];
  int          link_cyc_q[$];
  logic [7:0]  link_pc_q[$];
  bit          prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Ctrl/ack garbage driven whenever the DUT should ignore it.
  task automatic junk_ctrl();
    jctrl = 1'b1; jrctrl = 1'b1; beqctrl = 1'b1; jalctrl = 1'b1; zero = 1'b1; ra_in = 8'h33;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (imem_req) begin
        if (addr_q.size() == 0) check("unexpected_req", {24'd0, imem_addr}, 32'hFFFF_FFFF);
        else begin
          check("imem_addr", {24'd0, imem_addr}, {24'd0, addr_q[0]});
          if (imem_ack) void'(addr_q.pop_front());
        end
      end
      if (prev_valid) begin
        if (next_q.size() == 0) check("unexpected_next", {24'd0, pc}, 32'hFFFF_FFFF);
        else check("next_pc", {24'd0, pc}, {24'd0, next_q.pop_front()});
      end
      prev_valid = inst_valid;
      if (inst_valid) begin
        if (inst_q.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
        else begin
          logic [15:0] e;
          e = inst_q.pop_front();
          check("issue_pc", {24'd0, pc}, {24'd0, e[15:8]});
          check("inst1", {29'd0, inst1}, {29'd0, e[7:5]});
          check("inst2", {31'd0, inst2}, {31'd0, e[4]});
          check("imm", {28'd0, imm}, {28'd0, e[3:0]});
        end
      end
      if (link_we) begin
        if (link_pc_q.size() == 0) check("unexpected_link_we", 32'd1, 32'd0);
        else begin
          check("link_pc", {24'd0, link_pc}, {24'd0, link_pc_q.pop_front()});
          check("link_we_cycle", cyc, link_cyc_q.pop_front());
        end
      end
    end
  end

  task automatic run_vec(input vec_t v, input bit after_idle);
    int n = 0;
    addr_q.push_back(v.addr);
    while (!imem_req && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!imem_req) check("fetch_req_timeout", 32'd0, 32'd1);
    if (!after_idle) check("req_latency", n, 0);
    for (int d = 0; d < v.delay; d++) begin
      imem_ack = 1'b0; imem_rdata = 8'h5A;
      if (v.drop && d == 1) run = 1'b0;
      @(posedge clk); #1;
    end
    imem_ack = 1'b1; imem_rdata = v.rdata;
    inst_q.push_back({v.addr, v.rdata});
    @(posedge clk); #1;
    // ISSUE cycle: real ctrl, stray ack that must be ignored.
    imem_ack = 1'b1; imem_rdata = 8'hFF;
    jctrl = v.j; jrctrl = v.jr; beqctrl = v.beq; jalctrl = v.jal; zero = v.zr; ra_in = v.ra;
    run = v.run_next;
    next_q.push_back(v.next);
    if (v.jal) begin
      link_cyc_q.push_back(cyc + 1);
      link_pc_q.push_back(v.link);
    end
    @(posedge clk); #1;
    imem_ack = 1'b0;
    junk_ctrl();
  endtask

  function automatic vec_t mk(input logic [7:0] addr, rdata, input int delay, input bit drop,
                              input bit j, jr, beq, jal, zr, input logic [7:0] ra, next, link,
                              input bit run_next);
    vec_t v;
    v.addr = addr; v.rdata = rdata; v.delay = delay; v.drop = drop;
    v.j = j; v.jr = jr; v.beq = beq; v.jal = jal; v.zr = zr;
    v.ra = ra; v.next = next; v.link = link; v.run_next = run_next;
    return v;
  endfunction

  vec_t vecs[12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //             addr   rdata delay drop j  jr beq jal z  ra     next   link   run
    vecs[0]  = mk(8'h00, 8'h61, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h01, 8'h00, 1);
    vecs[1]  = mk(8'h01, 8'h01, 1, 0, 1, 0, 0, 0, 0, 8'h00, 8'h10, 8'h00, 1);
    vecs[2]  = mk(8'h10, 8'h0E, 0, 0, 0, 0, 1, 0, 1, 8'h00, 8'h0F, 8'h00, 1);
    vecs[3]  = mk(8'h0F, 8'h11, 0, 0, 1, 0, 0, 0, 0, 8'h00, 8'h10, 8'h00, 1);
    vecs[4]  = mk(8'h10, 8'hEE, 0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h11, 8'h00, 1);
    vecs[5]  = mk(8'h11, 8'h02, 2, 0, 1, 0, 0, 0, 0, 8'h00, 8'h20, 8'h00, 1);
    vecs[6]  = mk(8'h20, 8'h45, 0, 0, 0, 0, 0, 1, 0, 8'h00, 8'h50, 8'h21, 1);
    vecs[7]  = mk(8'h50, 8'h02, 0, 0, 1, 0, 0, 0, 0, 8'h00, 8'h20, 8'h00, 1);
    vecs[8]  = mk(8'h20, 8'hC5, 0, 0, 0, 1, 0, 1, 0, 8'hA7, 8'hA7, 8'h21, 1);
    vecs[9]  = mk(8'hA7, 8'h00, 0, 0, 0, 1, 0, 0, 0, 8'hFF, 8'hFF, 8'h00, 1);
    vecs[10] = mk(8'hFF, 8'h30, 3, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0);
    vecs[11] = mk(8'h00, 8'hA3, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h01, 8'h00, 1);

    rst_n = 1'b0; run = 1'b0; imem_ack = 1'b1; imem_rdata = 8'hC3;
    junk_ctrl();
    #12;
    check("rst_pc", {24'd0, pc}, 32'h00);
    check("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check("rst_imem_addr", {24'd0, imem_addr}, 32'h00);
    check("rst_ir", {24'd0, inst1, inst2, imm}, 32'h00);
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_link_pc", {24'd0, link_pc}, 32'h00);
    check("rst_link_we", {31'd0, link_we}, 32'd0);
    check("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("idle_no_req", {31'd0, imem_req}, 32'd0);
    end
    imem_ack = 1'b0;
    run = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i == 0);

    // run dropped mid-wait: unit parks in IDLE, IR held, stray acks ignored.
    imem_ack = 1'b1; imem_rdata = 8'h77;
    repeat (3) begin
      check("idle_req", {31'd0, imem_req}, 32'd0);
      check("idle_valid", {31'd0, inst_valid}, 32'd0);
      check("ir_hold", {24'd0, inst1, inst2, imm}, 32'h30);
      @(posedge clk); #1;
    end
    imem_ack = 1'b0;
    run = 1'b1;
    run_vec(vecs[11], 1'b1);

    // Reset in the middle of a fetch.
    addr_q.push_back(8'h01);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("midrst_req", {31'd0, imem_req}, 32'd0);
    check("midrst_pc", {24'd0, pc}, 32'h00);
    check("midrst_addr", {24'd0, imem_addr}, 32'h00);
    check("midrst_ir", {24'd0, inst1, inst2, imm}, 32'h00);
    addr_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_vec(mk(8'h00, 8'h61, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h01, 8'h00, 0), 1'b1);

`ifdef FETCH_TIMEOUT_EN
    run = 1'b1;
    addr_q.push_back(8'h01);
    repeat (18) begin
      @(posedge clk); #1;
    end
    run = 1'b0;
    check("halt_err", {31'd0, fetch_err}, 32'd1);
    check("halt_req", {31'd0, imem_req}, 32'd0);
    imem_ack = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("halt_sticky", {31'd0, fetch_err}, 32'd1);
    imem_ack = 1'b0;
    addr_q.delete();
`else
    repeat (20) begin
      @(posedge clk); #1;
    end
    check("no_fetch_err", {31'd0, fetch_err}, 32'd0);
`endif
    check("addr_q_drained", addr_q.size(), 0);
    check("inst_q_drained", inst_q.size(), 0);
    check("next_q_drained", next_q.size(), 0);
    check("link_q_drained", link_pc_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
